// File: rtl/morse_pkg.sv
// Shared Morse definitions: timing in units, code/length widths, decoder states and the
// character record exchanged between the driver stage, this decoder and benches.
package morse_pkg;
    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int CHAR_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS = 7;
    localparam int SAT_UNITS      = 8;
    localparam int CODE_W         = 8;
    localparam int LEN_W          = 4;

    typedef enum logic [1:0] {IDLE, MARK, GAP, WORDGAP} dec_state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
    } morse_char_t;
endpackage

// File: rtl/morse_led_decoder_if.sv
// LED stream in, decoded character/space pulses out; slave is the decoder side.
interface morse_led_decoder_if;
    import morse_pkg::*;

    logic              led_in;
    logic              out_vald;
    logic [CODE_W-1:0] out_code;
    logic [LEN_W-1:0]  out_len;
    logic              out_space;
    logic              out_err;
    logic              busy;

    modport master (output led_in,
                    input  out_vald, out_code, out_len, out_space, out_err, busy);
    modport slave  (input  led_in,
                    output out_vald, out_code, out_len, out_space, out_err, busy);
endinterface

// File: rtl/morse_run_counter.sv
// Saturating run-length counter: counts consecutive samples with level=1, clears on level=0.
// Latency 1 cycle (registered count); no backpressure.
module morse_run_counter #(
    parameter int W   = 4,
    parameter int SAT = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         level,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] SAT_V = W'(SAT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!level)
            cnt <= '0;
        else if (cnt != SAT_V)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/morse_led_decoder.sv
// Decodes the Morse LED stream into MSB-first dash=1 codes plus word-space pulses.
// Results register on the qualifying sample's edge (0-cycle latency); no backpressure.
module morse_led_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYC = 1,
    parameter int MAX_SYM  = 8
) (
    input logic                clock,
    input logic                reset,
    morse_led_decoder_if.slave bus
);
    localparam int CNT_W = $clog2(SAT_UNITS*UNIT_CYC+1);

    localparam logic [CNT_W-1:0]  DOT_LEN   = CNT_W'(DOT_UNITS*UNIT_CYC);
    localparam logic [CNT_W-1:0]  DASH_LEN  = CNT_W'(DASH_UNITS*UNIT_CYC);
    // Counts are registered, so the N-th low is seen while off_cnt still holds N-1.
    localparam logic [CNT_W-1:0]  CHAR_LAST = CNT_W'(CHAR_GAP_UNITS*UNIT_CYC-1);
    localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_GAP_UNITS*UNIT_CYC-1);
    localparam logic [LEN_W-1:0]  MAX_SYM_V = LEN_W'(MAX_SYM);
    localparam logic [CODE_W-1:0] MSB_ONE   = {1'b1, {(CODE_W-1){1'b0}}};

    logic [CNT_W-1:0] on_cnt, off_cnt;
    logic             led, led_low;

    assign led     = bus.led_in;
    assign led_low = ~bus.led_in;

    morse_run_counter #(.W(CNT_W), .SAT(SAT_UNITS*UNIT_CYC)) u_on_cnt (
        .clock (clock), .reset (reset), .level (led),     .cnt (on_cnt)
    );
    morse_run_counter #(.W(CNT_W), .SAT(SAT_UNITS*UNIT_CYC)) u_off_cnt (
        .clock (clock), .reset (reset), .level (led_low), .cnt (off_cnt)
    );

    dec_state_t        state_q, state_d;
    logic [LEN_W-1:0]  sym_q, sym_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              err_q, err_d;
    morse_char_t       res_q, res_d;
    logic              vld_q, vld_d;
    logic              space_q, space_d;
    logic              oerr_q, oerr_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sym_q   <= '0;
            code_q  <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            space_q <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            code_q  <= code_d;
            err_q   <= err_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            space_q <= space_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        code_d  = code_q;
        err_d   = err_q;
        res_d   = res_q;
        vld_d   = 1'b0;
        space_d = space_q;
        oerr_d  = oerr_q;
        case (state_q)
            IDLE: begin
                if (led)
                    state_d = MARK;
            end
            MARK: begin
                if (!led) begin
                    state_d = GAP;
                    if (sym_q == MAX_SYM_V) begin
                        err_d = 1'b1;
                    end else if (on_cnt == DOT_LEN) begin
                        sym_d = sym_q + LEN_W'(1);
                    end else if (on_cnt == DASH_LEN) begin
                        code_d = code_q | (MSB_ONE >> sym_q);
                        sym_d  = sym_q + LEN_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GAP: begin
                if (led) begin
                    state_d = MARK;
                end else if (off_cnt == CHAR_LAST) begin
                    vld_d    = 1'b1;
                    res_d    = '{code: code_q, len: sym_q};
                    space_d  = 1'b0;
                    oerr_d   = err_q;
                    sym_d    = '0;
                    code_d   = '0;
                    err_d    = 1'b0;
                    state_d  = WORDGAP;
                end
            end
            WORDGAP: begin
                if (led) begin
                    state_d = MARK;
                end else if (off_cnt == WORD_LAST) begin
                    vld_d   = 1'b1;
                    res_d   = '0;
                    space_d = 1'b1;
                    oerr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_vald  = vld_q;
    assign bus.out_code  = res_q.code;
    assign bus.out_len   = res_q.len;
    assign bus.out_space = space_q;
    assign bus.out_err   = oerr_q;
    assign bus.busy      = (state_q == MARK) | (state_q == GAP);
endmodule

// File: tb/tb_morse_led_decoder.sv
// Directed bench for morse_led_decoder at UNIT_CYC=1 with hand-computed expectations.
module tb_morse_led_decoder;
    import morse_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks  = 0;
    int   errors  = 0;
    int   vld_cnt = 0;
    int   seg     = 0;

    morse_led_decoder_if bus();

    morse_led_decoder #(.UNIT_CYC(1), .MAX_SYM(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v);
        bus.led_in = v;
        @(posedge clock);
        #1;
        if (bus.out_vald === 1'b1) vld_cnt++;
    endtask

    task automatic ticks(input logic v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    task automatic chk_out(input string tag, input logic vld, input logic [7:0] code,
                           input logic [3:0] len, input logic sp, input logic er);
        chk({tag, ".vld"},   32'(bus.out_vald),  32'(vld));
        chk({tag, ".code"},  32'(bus.out_code),  32'(code));
        chk({tag, ".len"},   32'(bus.out_len),   32'(len));
        chk({tag, ".space"}, 32'(bus.out_space), 32'(sp));
        chk({tag, ".err"},   32'(bus.out_err),   32'(er));
    endtask

    initial begin
        bus.led_in = 1'b0;
        reset      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_out("reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        reset = 1'b1;

        // Leading silence after reset produces nothing.
        ticks(1'b0, 10);
        chk("idle.pulses", vld_cnt, 32'd0);
        chk("idle.busy", 32'(bus.busy), 32'd0);

        // 'M' = dash dash
        ticks(1'b1, 3);
        chk("m.busy_mark", 32'(bus.busy), 32'd1);
        tick(1'b0);
        ticks(1'b1, 3);
        ticks(1'b0, 2);
        chk("m.busy_gap", 32'(bus.busy), 32'd1);
        chk("m.early", 32'(bus.out_vald), 32'd0);
        tick(1'b0);
        chk_out("m", 1'b1, 8'hC0, 4'd2, 1'b0, 1'b0);
        chk("m.busy_wordgap", 32'(bus.busy), 32'd0);
        tick(1'b0);
        chk_out("m.hold", 1'b0, 8'hC0, 4'd2, 1'b0, 1'b0);
        ticks(1'b0, 3);
        chk_out("m.space", 1'b1, 8'h00, 4'd0, 1'b1, 1'b0);
        tick(1'b0);
        chk_out("m.space_hold", 1'b0, 8'h00, 4'd0, 1'b1, 1'b0);

        // "TA" then word gap
        ticks(1'b1, 3);
        ticks(1'b0, 3);
        chk_out("t", 1'b1, 8'h80, 4'd1, 1'b0, 1'b0);
        seg = vld_cnt;
        tick(1'b1);
        tick(1'b0);
        ticks(1'b1, 3);
        ticks(1'b0, 3);
        chk_out("a", 1'b1, 8'h40, 4'd2, 1'b0, 1'b0);
        ticks(1'b0, 4);
        chk_out("a.space", 1'b1, 8'h00, 4'd0, 1'b1, 1'b0);
        ticks(1'b0, 10);
        chk("a.pulses", vld_cnt - seg, 32'd2);

        // Malformed 2-unit mark, then a clean dot
        ticks(1'b1, 2);
        ticks(1'b0, 3);
        chk_out("bad", 1'b1, 8'h00, 4'd0, 1'b0, 1'b1);
        tick(1'b1);
        ticks(1'b0, 3);
        chk_out("dot", 1'b1, 8'h00, 4'd1, 1'b0, 1'b0);
        ticks(1'b0, 4);
        chk_out("dot.space", 1'b1, 8'h00, 4'd0, 1'b1, 1'b0);

        // Overflow: nine dots
        for (int i = 0; i < 9; i++) begin
            tick(1'b1);
            tick(1'b0);
        end
        ticks(1'b0, 2);
        chk_out("ovf", 1'b1, 8'h00, 4'd8, 1'b0, 1'b1);
        ticks(1'b0, 4);
        chk_out("ovf.space", 1'b1, 8'h00, 4'd0, 1'b1, 1'b0);

        // Reset in the middle of a dash
        ticks(1'b1, 2);
        chk("rst.busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        ticks(1'b0, 2);
        reset = 1'b1;
        seg = vld_cnt;
        ticks(1'b0, 20);
        chk("rst.pulses", vld_cnt - seg, 32'd0);

        // Stuck-on LED
        seg = vld_cnt;
        ticks(1'b1, 50);
        chk("stuck.busy", 32'(bus.busy), 32'd1);
        ticks(1'b0, 2);
        chk("stuck.early", 32'(bus.out_vald), 32'd0);
        tick(1'b0);
        chk_out("stuck", 1'b1, 8'h00, 4'd0, 1'b0, 1'b1);
        chk("stuck.pulses", vld_cnt - seg, 32'd1);
        reset = 1'b0;
        tick(1'b0);
        reset = 1'b1;
        seg = vld_cnt;
        ticks(1'b0, 30);
        chk("stuck.rst_pulses", vld_cnt - seg, 32'd0);
        chk_out("stuck.rst", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
